// File: rtl/m_imem_loader.sv
// Boot loader: parses a length-prefixed byte stream and writes 32-bit words
// into instruction memory from address 0. It raises the core clock-enable only after the checksum matches.
module m_imem_loader #(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 1000000
) (
  input  logic              w_clk,
  input  logic              w_rst_n,
  input  logic [7:0]        w_rx_data,
  input  logic              w_rx_valid,
  output logic              w_we,
  output logic [ADDR_W-1:0] w_addr,
  output logic [31:0]       w_din,
  output logic              w_ce,
  output logic              w_busy,
  output logic              w_err
);

  typedef enum logic [2:0] {S_LEN0, S_LEN1, S_DATA, S_CSUM, S_RUN, S_ERR} state_t;

  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t            state_q, state_d;
  logic [7:0]        lenlo_q, lenlo_d;
  logic [ADDR_W:0]   n_q, n_d;
  logic [ADDR_W:0]   wcnt_q, wcnt_d, wnext;
  logic [1:0]        bidx_q, bidx_d;
  logic [23:0]       asm_q, asm_d;
  logic [7:0]        csum_q, csum_d;
  logic [IW-1:0]     idle_q, idle_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       din_q, din_d;
  logic              ce_q, ce_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [15:0]       n_full;
  logic              timed;

  always_comb begin
    state_d = state_q;
    lenlo_d = lenlo_q;
    n_d     = n_q;
    wcnt_d  = wcnt_q;
    bidx_d  = bidx_q;
    asm_d   = asm_q;
    csum_d  = csum_q;
    idle_d  = idle_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;
    ce_d    = ce_q;
    busy_d  = busy_q;
    err_d   = err_q;
    n_full  = {w_rx_data, lenlo_q};
    wnext   = wcnt_q + 1'b1;
    timed   = (TIMEOUT != 0) &&
              (state_q == S_LEN1 || state_q == S_DATA || state_q == S_CSUM);

    if (timed) idle_d = w_rx_valid ? '0 : idle_q + 1'b1;

    case (state_q)
      S_LEN0, S_ERR: if (w_rx_valid) begin
        lenlo_d = w_rx_data;
        busy_d  = 1'b1;
        err_d   = 1'b0;
        idle_d  = '0;
        state_d = S_LEN1;
      end
      S_LEN1: if (w_rx_valid) begin
        // N is 1..2^ADDR_W; anything else is rejected before a single write
        if (n_full == 16'd0 || 32'(n_full) > (32'd1 << ADDR_W)) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_ERR;
        end else begin
          n_d     = (ADDR_W+1)'(n_full);
          wcnt_d  = '0;
          bidx_d  = '0;
          csum_d  = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: if (w_rx_valid) begin
        csum_d = csum_q ^ w_rx_data;
        bidx_d = bidx_q + 2'd1;
        if (bidx_q == 2'd3) begin
          we_d   = 1'b1;
          addr_d = wcnt_q[ADDR_W-1:0];
          din_d  = {w_rx_data, asm_q};
          wcnt_d = wnext;
          if (wnext == n_q) state_d = S_CSUM;
        end else begin
          asm_d[8*bidx_q +: 8] = w_rx_data;
        end
      end
      S_CSUM: if (w_rx_valid) begin
        busy_d = 1'b0;
        if (w_rx_data == csum_q) begin
          ce_d    = 1'b1;
          state_d = S_RUN;
        end else begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end
      end
      S_RUN: ;
      default: state_d = S_LEN0;
    endcase

    // Stalled sender: drop the frame, any half-built word is never written
    if (timed && !w_rx_valid && idle_q == IDLE_LAST) begin
      err_d   = 1'b1;
      busy_d  = 1'b0;
      idle_d  = '0;
      state_d = S_ERR;
    end
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q <= S_LEN0;
      lenlo_q <= '0;
      n_q     <= '0;
      wcnt_q  <= '0;
      bidx_q  <= '0;
      asm_q   <= '0;
      csum_q  <= '0;
      idle_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      ce_q    <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lenlo_q <= lenlo_d;
      n_q     <= n_d;
      wcnt_q  <= wcnt_d;
      bidx_q  <= bidx_d;
      asm_q   <= asm_d;
      csum_q  <= csum_d;
      idle_q  <= idle_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      ce_q    <= ce_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign w_we   = we_q;
  assign w_addr = addr_q;
  assign w_din  = din_q;
  assign w_ce   = ce_q;
  assign w_busy = busy_q;
  assign w_err  = err_q;

endmodule

// File: tb/tb_m_imem_loader.sv
// Directed bench for m_imem_loader; expected writes are queued as words are sent
// and popped when the write pulse appears.
module tb_m_imem_loader;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          w_we, w_ce, w_busy, w_err;
  logic [AW-1:0] w_addr;
  logic [31:0]   w_din;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [43:0] exp_q[$];
  logic [7:0]  csum;

  m_imem_loader #(.ADDR_W(AW), .TIMEOUT(16)) dut (
    .w_clk(clk), .w_rst_n(rst_n), .w_rx_data(rx_data), .w_rx_valid(rx_valid),
    .w_we(w_we), .w_addr(w_addr), .w_din(w_din), .w_ce(w_ce),
    .w_busy(w_busy), .w_err(w_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mon();
    logic [43:0] e;
    if (w_we === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_we", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(w_addr), 32'(e[43:32]));
        chk("wr_din", w_din, e[31:0]);
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    mon();
  endtask

  task automatic send_word(input logic [AW-1:0] a, input logic [31:0] w);
    exp_q.push_back({a, w});
    csum ^= w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_byte(w[31:24]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      mon();
    end
  endtask

  task automatic hard_reset();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic good_frame(input logic [7:0] last);
    csum = '0;
    send_byte(8'h02);
    chk("gf_busy_b1", w_busy, 1);
    chk("gf_err_b1", w_err, 0);
    send_byte(8'h00);
    send_word(0, 32'h0000_0013);
    send_word(1, 32'h000f_0033);
    chk("gf_ce_pre", w_ce, 0);
    chk("gf_busy_pre", w_busy, 1);
    send_byte(last);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", w_we, 0);
    chk("rst_addr", 32'(w_addr), 0);
    chk("rst_din", w_din, 0);
    chk("rst_ce", w_ce, 0);
    chk("rst_busy", w_busy, 0);
    chk("rst_err", w_err, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // bad checksum: both words land, error flagged, no clock-enable
    good_frame(8'h2e);
    chk("bad_err", w_err, 1);
    chk("bad_ce", w_ce, 0);
    chk("bad_busy", w_busy, 0);
    chk("bad_q", exp_q.size(), 0);

    // replay good frame
    good_frame(8'h2f);
    chk("good_ce", w_ce, 1);
    chk("good_err", w_err, 0);
    chk("good_busy", w_busy, 0);
    chk("good_q", exp_q.size(), 0);

    // bytes after run are ignored
    for (int i = 0; i < 20; i++) begin
      send_byte(8'($urandom_range(0, 255)));
      chk("run_we", w_we, 0);
    end
    chk("run_ce", w_ce, 1);
    chk("run_err", w_err, 0);
    chk("run_busy", w_busy, 0);

    // length errors and max length
    hard_reset();
    send_byte(8'h00); send_byte(8'h00);
    chk("len0_err", w_err, 1);
    chk("len0_busy", w_busy, 0);
    send_byte(8'h01);
    chk("lenbig_err_clr", w_err, 0);
    chk("lenbig_busy", w_busy, 1);
    send_byte(8'h10);
    chk("lenbig_err", w_err, 1);
    chk("lenbig_busy2", w_busy, 0);
    chk("len_q", exp_q.size(), 0);
    csum = '0;
    send_byte(8'h00); send_byte(8'h10);
    chk("lenmax_err", w_err, 0);
    chk("lenmax_busy", w_busy, 1);
    for (int k = 0; k < 4096; k++) send_word(AW'(k), 32'(k) * 32'h9E37_79B1);
    chk("lenmax_addr", 32'(w_addr), 32'hfff);
    send_byte(csum);
    chk("lenmax_ce", w_ce, 1);
    chk("lenmax_err2", w_err, 0);
    chk("lenmax_q", exp_q.size(), 0);

    // timeout: partial word is discarded
    hard_reset();
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h13); send_byte(8'h00);
    idle(15);
    chk("to_err_early", w_err, 0);
    chk("to_busy_early", w_busy, 1);
    idle(1);
    chk("to_err", w_err, 1);
    chk("to_busy", w_busy, 0);
    idle(3);
    good_frame(8'h2f);
    chk("to_good_ce", w_ce, 1);
    chk("to_good_err", w_err, 0);
    chk("to_q", exp_q.size(), 0);

    // asynchronous reset in the middle of a frame
    hard_reset();
    csum = '0;
    send_byte(8'h03); send_byte(8'h00);
    send_word(0, 32'h1122_3344);
    send_word(1, 32'h5566_7788);
    send_byte(8'h99); send_byte(8'haa);
    chk("mid_din_pre", w_din, 32'h5566_7788);
    chk("mid_busy_pre", w_busy, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_we", w_we, 0);
    chk("mid_addr", 32'(w_addr), 0);
    chk("mid_din", w_din, 0);
    chk("mid_busy", w_busy, 0);
    chk("mid_err", w_err, 0);
    chk("mid_ce", w_ce, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    good_frame(8'h2f);
    chk("mid_good_ce", w_ce, 1);
    chk("mid_good_err", w_err, 0);
    chk("mid_q", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/m_imem_loader.md
# m_imem_loader

Boot-time writer for the instruction memory write port, which is otherwise tied off. Consumes a framed byte stream from a serial receiver and writes 32-bit words into instruction memory from word address 0 upward. Verifies a checksum and only then raises the processor clock-enable. This lets the pipeline run a new program without re-synthesising the memory image.

## Interface
Parameters:
- ADDR_W, 12: instruction-memory word-address width; maximum program is 2^ADDR_W words.
- TIMEOUT, 1000000: maximum idle cycles allowed between bytes inside a frame; 0 disables the timeout.

Ports (one clock; reset is asynchronous and active-low):
- w_clk  input  1  system clock; all state changes on its rising edge.
- w_rst_n  input  1  asynchronous active-low reset.
- w_rx_data  input  8  received byte; valid only while w_rx_valid is high.
- w_rx_valid  input  1  one-cycle strobe per byte; may be high on consecutive cycles.
- w_we  output  1  instruction-memory write enable, one-cycle pulse per word.
- w_addr  output  ADDR_W  instruction-memory word address.
- w_din  output  32  instruction word to write.
- w_ce  output  1  processor clock-enable; high only after a verified load.
- w_busy  output  1  a frame is in progress.
- w_err  output  1  sticky error flag; cleared by the first byte of the next frame.

## Operation
- Frame format, in order:
  - LEN_LO, LEN_HI: 16-bit word count N, little-endian.
  - N×4 payload bytes: each word little-endian; word k goes to address k.
  - CSUM: one byte equal to the XOR of all payload bytes. The header is excluded.
- States: S_LEN0, S_LEN1, S_DATA, S_CSUM, S_RUN, S_ERR. The reset state is S_LEN0.
- S_LEN0:
  - Byte → latch low half of N; w_busy←1; w_err←0; S_LEN1.
- S_LEN1:
  - Byte → latch high half of N.
  - If N==0 or N>2^ADDR_W: w_err←1, w_busy←0, S_ERR.
  - Otherwise clear the word counter, byte index and checksum accumulator; S_DATA.
- S_DATA:
  - Each byte is shifted into bits [8i+7:8i] of the assembly register (i = byte index 0..3) and XORed into the accumulator.
  - On i==3: w_we←1, w_addr←word counter, w_din←assembled word; the word counter increments.
  - After word N-1 is written: S_CSUM.
- S_CSUM:
  - Byte equal to accumulator: w_ce←1, w_busy←0, S_RUN.
  - Byte not equal: w_err←1, w_busy←0, S_ERR.
- S_RUN: terminal until reset. All bytes are ignored; w_we never asserts. The program cannot be reloaded without reset.
- S_ERR: w_ce stays 0. The next byte is treated as LEN_LO: w_err←0, w_busy←1, S_LEN1.
- Words already written by a failed frame remain in memory. A later good frame overwrites them from address 0.
- Timeout, in S_LEN1, S_DATA and S_CSUM only:
  - An idle counter resets on each byte and increments otherwise.
  - When it reaches TIMEOUT: w_err←1, w_busy←0, S_ERR.
  - A partially assembled word is discarded, not written.

## Timing
- Reset values: w_we=0, w_addr=0, w_din=0, w_ce=0, w_busy=0, w_err=0. Reset also clears all counters and the accumulator.
- All outputs are registered. Write pulse:
  - The 4th byte of a word sampled at edge t gives w_we=1 with w_addr/w_din valid for the cycle after t.
  - w_we=0 at edge t+1 unless another word completes then (impossible: at least 4 bytes per word).
  - w_addr/w_din hold their last value while w_we=0.
- The checksum byte sampled at edge t gives w_ce=1 after t. w_ce stays 1 until reset.
- Back-to-back bytes are accepted with no stall. There is no backpressure, and no byte is dropped in any state except S_RUN.
- Reset assertion mid-frame:
  - Immediately forces all outputs to reset values; the frame is abandoned.
  - After release, loading restarts at S_LEN0.
- Word counter width is ADDR_W+1 so N=2^ADDR_W terminates correctly. w_addr reaches 2^ADDR_W-1 and never wraps.

## Test plan
- Good load, bytes back-to-back: 02 00 13 00 00 00 33 00 0f 00 2f.
  - w_we pulses twice: addr 0 with 0x00000013, then addr 1 with 0x000f0033.
  - w_ce=1 the cycle after byte 0x2f; w_err=0; w_busy high from byte 1 until the CSUM edge.
- Bad checksum: the same frame ending in 0x2e.
  - Both writes occur; w_err=1; w_ce=0.
  - Replaying the good frame clears w_err on its first byte and ends with w_ce=1.
- Length errors:
  - 00 00 → w_err=1 after the 2nd byte, no writes.
  - 01 10 (N=4097, ADDR_W=12) → same result.
  - 00 10 (N=4096) is accepted.
- Timeout with TIMEOUT=16: send 02 00 13 00, then stay idle for 16 cycles.
  - w_err=1, w_busy=0, no w_we pulse.
  - A subsequent good frame loads normally.
- Reset mid-frame: assert w_rst_n=0 between payload bytes, asynchronously, not on a clock edge.
  - Outputs clear at once, without waiting for a clock edge.
  - After release, the good frame loads to address 0.
- Bytes after S_RUN: send 20 random bytes once w_ce=1.
  - w_we stays 0; w_ce, w_err and w_busy are unchanged.
